// File: rtl/mod_cpu_clock_ctrl.sv
// Run/single-step clock-enable controller: turns div_clk rising edges into one-cycle cpu_en pulses.
// Optional `CYCLE_COUNT_EN adds a 32-bit cycle_count output counting issued pulses.
module mod_cpu_clock_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        div_clk,
    input  logic        step_btn,
    input  logic        run_sw,
    input  logic        halt,
    output logic        cpu_en,
    output logic        mode_run,
`ifdef CYCLE_COUNT_EN
    output logic        halted,
    output logic [31:0] cycle_count
`else
    output logic        halted
`endif
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        STEP_ARMED    = 3'd0,
        STEP_PEND     = 3'd1,
        STEP_WAIT_REL = 3'd2,
        RUN           = 3'd3,
        HALTED        = 3'd4
    } state_t;

    state_t state, state_next;

    // Index 0 is the step button, index 1 the run switch.
    logic [1:0]             raw_in;
    logic [SYNC_STAGES-1:0] sync_chain [2];
    logic [1:0]             synced;
    logic [1:0]             stable;
    logic [CW-1:0]          db_cnt [2];

    logic step_db, run_db, step_db_q, step_rise;
    logic div_s1, div_s2, tick;
    logic issue, cpu_en_next;

    assign raw_in = {run_sw, step_btn};

    for (genvar g = 0; g < 2; g++) begin : g_in
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync_chain[g] <= '0;
            end else begin
                sync_chain[g] <= {sync_chain[g][SYNC_STAGES-2:0], raw_in[g]};
            end
        end

        assign synced[g] = sync_chain[g][SYNC_STAGES-1];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                db_cnt[g] <= '0;
                stable[g] <= 1'b0;
            end else if (synced[g] == stable[g]) begin
                db_cnt[g] <= '0;
            end else if (db_cnt[g] == CNT_MAX) begin
                stable[g] <= synced[g];
                db_cnt[g] <= '0;
            end else begin
                db_cnt[g] <= db_cnt[g] + 1'b1;
            end
        end
    end

    assign step_db = stable[0];
    assign run_db  = stable[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_db_q <= 1'b0;
            div_s1    <= 1'b0;
            div_s2    <= 1'b0;
        end else begin
            step_db_q <= step_db;
            div_s1    <= div_clk;
            div_s2    <= div_s1;
        end
    end

    assign step_rise = step_db & ~step_db_q;
    assign tick      = div_s1 & ~div_s2;

    // State register; status flags decode the next state so they track state exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= STEP_ARMED;
            mode_run <= 1'b0;
            halted   <= 1'b0;
            cpu_en   <= 1'b0;
        end else begin
            state    <= state_next;
            mode_run <= (state_next == RUN);
            halted   <= (state_next == HALTED);
            cpu_en   <= cpu_en_next;
        end
    end

    always_comb begin
        state_next = state;
        if (halt) begin
            state_next = HALTED;
        end else begin
            case (state)
                HALTED:        state_next = HALTED;
                STEP_ARMED: begin
                    if (run_db)         state_next = RUN;
                    else if (step_rise) state_next = STEP_PEND;
                end
                STEP_PEND: begin
                    if (run_db)         state_next = RUN;
                    else if (tick)      state_next = STEP_WAIT_REL;
                end
                STEP_WAIT_REL: begin
                    if (run_db)         state_next = RUN;
                    else if (!step_db)  state_next = STEP_ARMED;
                end
                RUN: begin
                    if (!run_db)        state_next = STEP_ARMED;
                end
                default:       state_next = STEP_ARMED;
            endcase
        end
    end

    // A pending step is dropped when the run switch wins in the same cycle.
    always_comb begin
        issue = 1'b0;
        case (state)
            RUN:       issue = tick;
            STEP_PEND: issue = tick & ~run_db;
            default:   issue = 1'b0;
        endcase
        cpu_en_next = issue & ~halt;
    end

`ifdef CYCLE_COUNT_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
        end else if (cpu_en && state != HALTED) begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    assign cycle_count = cycle_cnt;
`endif

endmodule
